// File: rtl/fence_barrier_pkg.sv
// Shared types and constants for the fence barrier.
package fence_barrier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fence_state_t;

  localparam int unsigned N_INS_MIN = 2;
  localparam int unsigned N_INS_MAX = 32;

endpackage

// File: rtl/and_.sv
// Parameterised AND-reduction gate: o_y = 1 only when every input bit is 1.
module and_ #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] i_a,
  output logic         o_y
);

  assign o_y = &i_a;

endmodule

// File: rtl/fence_barrier.sv
// Fence barrier: captures a mask of units to drain, collects sticky per-unit
// done pulses and issues one response once every masked unit has reported.
// Optional watchdog release is enabled with `define FENCE_BARRIER_TIMEOUT_EN.
module fence_barrier
  import fence_barrier_pkg::*;
#(
  parameter int unsigned N_INS     = 8,
  parameter int unsigned TIMEOUT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N_INS-1:0] req_mask,
  input  logic [N_INS-1:0] unit_done,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_timeout,
  output logic             busy
);

  if ((N_INS < N_INS_MIN) || (N_INS > N_INS_MAX)) begin : g_bad_n_ins
    $error("fence_barrier: N_INS out of legal range 2..32");
  end

  if (TIMEOUT_W < 1) begin : g_bad_timeout_w
    $error("fence_barrier: TIMEOUT_W must be at least 1");
  end

  fence_state_t     r_state;
  logic [N_INS-1:0] r_wait_mask;
  logic [N_INS-1:0] r_done;

  logic [N_INS-1:0] w_mask;
  logic [N_INS-1:0] w_done_next;
  logic [N_INS-1:0] w_and_in;
  logic             w_all_ok;
  logic             w_accept;

  // The single reduction serves both the accept cycle (fresh mask, pulses of
  // that cycle only) and WAIT (captured mask, accumulated done bits).
  always_comb begin
    w_mask      = (r_state == IDLE) ? req_mask : r_wait_mask;
    w_done_next = ((r_state == IDLE) ? '0 : r_done) | (unit_done & w_mask);
    w_and_in    = w_done_next | ~w_mask;
  end

  and_ #(.N(N_INS)) u_and (
    .i_a (w_and_in),
    .o_y (w_all_ok)
  );

  assign req_ready  = (r_state == IDLE) && !flush;
  assign w_accept   = req_valid && req_ready;
  assign resp_valid = (r_state == RESP);
  assign busy       = (r_state != IDLE);

`ifdef FENCE_BARRIER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_timer;
  logic                 r_timeout;
  logic                 w_expire;

  assign w_expire     = (r_timer == '1) && !w_all_ok;
  assign resp_timeout = r_timeout;

  // Barrier FSM with watchdog; rst and flush both abort to IDLE.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state     <= IDLE;
      r_wait_mask <= '0;
      r_done      <= '0;
      r_timer     <= '0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_wait_mask <= req_mask;
            r_done      <= w_done_next;
            r_timer     <= '0;
            r_timeout   <= 1'b0;
            r_state     <= w_all_ok ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_done <= w_done_next;
          if (w_all_ok) begin
            r_state <= RESP;
          end else if (w_expire) begin
            r_state   <= RESP;
            r_timeout <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state     <= IDLE;
            r_wait_mask <= '0;
            r_done      <= '0;
            r_timeout   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`else
  assign resp_timeout = 1'b0;

  // Barrier FSM without watchdog; rst and flush both abort to IDLE.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state     <= IDLE;
      r_wait_mask <= '0;
      r_done      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_wait_mask <= req_mask;
            r_done      <= w_done_next;
            r_state     <= w_all_ok ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_done <= w_done_next;
          if (w_all_ok) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state     <= IDLE;
            r_wait_mask <= '0;
            r_done      <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_fence_barrier.sv
// Self-checking bench for fence_barrier (N_INS=8, TIMEOUT_W=4).
module tb_fence_barrier;

  localparam int unsigned N  = 8;
  localparam int unsigned TW = 4;

  logic         clk = 1'b0;
  logic         rst, flush, req_valid, resp_ready;
  logic [N-1:0] req_mask, unit_done;
  logic         req_ready, resp_valid, resp_timeout, busy;

  always #5 clk = ~clk;

  fence_barrier #(.N_INS(N), .TIMEOUT_W(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mask     (req_mask),
    .unit_done    (unit_done),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_timeout (resp_timeout),
    .busy         (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       rst, flush, rv;
    logic [7:0] mask, done;
    logic       rdy;
    logic       e_rr, e_rv, e_busy, e_to;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic f, input logic v,
                              input logic [7:0] m, input logic [7:0] d,
                              input logic k, input logic err, input logic erv,
                              input logic eb, input logic eto);
    vec_t x;
    x.rst = r; x.flush = f; x.rv = v; x.mask = m; x.done = d; x.rdy = k;
    x.e_rr = err; x.e_rv = erv; x.e_busy = eb; x.e_to = eto;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic v,
                       input logic [7:0] m, input logic [7:0] d, input logic k);
    rst = r; flush = f; req_valid = v; req_mask = m; unit_done = d; resp_ready = k;
  endtask

  // One clock: inputs already driven, then release inputs and settle before sampling.
  task automatic cycle();
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    #1;
  endtask

  task automatic check_out(input string tag, input int idx, input logic e_rr,
                           input logic e_rv, input logic e_busy, input logic e_to);
    chk({tag, "_req_ready"}, idx, 32'(req_ready), 32'(e_rr));
    chk({tag, "_resp_valid"}, idx, 32'(resp_valid), 32'(e_rv));
    chk({tag, "_busy"}, idx, 32'(busy), 32'(e_busy));
    chk({tag, "_resp_timeout"}, idx, 32'(resp_timeout), 32'(e_to));
  endtask

  // Reference model: tracks the set of units still outstanding.
  logic       m_active, m_resp, m_to;
  logic [7:0] m_need;
  int         m_cnt;

  task automatic model_step(input logic r, input logic f, input logic v,
                            input logic [7:0] m, input logic [7:0] d, input logic k);
    if (r || f) begin
      m_active = 0; m_resp = 0; m_to = 0; m_need = 0; m_cnt = 0;
    end else if (!m_active) begin
      if (v) begin
        m_active = 1;
        m_need   = m & ~d;
        m_resp   = (m_need == 0);
        m_to     = 0;
        m_cnt    = 0;
      end
    end else if (m_resp) begin
      if (k) begin
        m_active = 0; m_resp = 0; m_to = 0;
      end
    end else begin
      m_need = m_need & ~d;
      if (m_need == 0) m_resp = 1;
`ifdef FENCE_BARRIER_TIMEOUT_EN
      else if (m_cnt == (1 << TW) - 1) begin
        m_resp = 1;
        m_to   = 1;
      end else m_cnt++;
`endif
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    #2;

    //        rst fl  v  mask   done   rdy  rr rv bsy to
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0)); // reset
    // mask 05: bit0 at t+2, bit2 at t+5 -> response after edge t+5
    vecs.push_back(mk(0, 0, 1, 8'h05, 8'h00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h01, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'hFF, 8'h02, 1, 0, 0, 1, 0)); // ignored req/pulse/ready
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h01, 0, 0, 0, 1, 0)); // repeat pulse
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h04, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0)); // handshake
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0)); // single response
    // empty mask: immediate response; no accept on handshake cycle
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h00, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h00, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));
    // full mask satisfied in accept cycle; then unmasked pulses never release
    vecs.push_back(mk(0, 0, 1, 8'hFF, 8'hFF, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h01, 8'hFE, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'hFE, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'hFE, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'hFE, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h01, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0));
    // response held under backpressure, then flush with resp_ready
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h00, 0, 0, 1, 1, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));
    // flush drops a simultaneous request
    vecs.push_back(mk(0, 1, 1, 8'h00, 8'h00, 0, 1, 0, 0, 0));
    // rst with flush and request mid-WAIT, then a fresh request completes
    vecs.push_back(mk(0, 0, 1, 8'h0F, 8'h00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h01, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 8'hFF, 8'hFF, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h80, 8'h00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h80, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].rv, vecs[i].mask, vecs[i].done, vecs[i].rdy);
      cycle();
      check_out("vec", i, vecs[i].e_rr, vecs[i].e_rv, vecs[i].e_busy, vecs[i].e_to);
    end

    // flush gates req_ready combinationally while IDLE
    flush = 1'b1;
    #1;
    chk("flush_gates_ready", 0, 32'(req_ready), 32'd0);
    flush = 1'b0;
    #1;
    chk("flush_gates_ready", 1, 32'(req_ready), 32'd1);

`ifdef FENCE_BARRIER_TIMEOUT_EN
    // watchdog release after 16 WAIT cycles, then normal release on the last cycle
    for (int pass = 0; pass < 2; pass++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      cycle();
      drive(1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0);
      cycle();
      for (int k = 0; k < 15; k++) begin
        cycle();
        chk("to_wait_resp_valid", pass * 100 + k, 32'(resp_valid), 32'd0);
      end
      if (pass == 1) unit_done = 8'h01;
      cycle();
      chk("to_release_resp_valid", pass, 32'(resp_valid), 32'd1);
      chk("to_release_resp_timeout", pass, 32'(resp_timeout), (pass == 0) ? 32'd1 : 32'd0);
      resp_ready = 1'b1;
      cycle();
      chk("to_handshake_resp_valid", pass, 32'(resp_valid), 32'd0);
      chk("to_handshake_resp_timeout", pass, 32'(resp_timeout), 32'd0);
    end
`endif

    // randomized traffic against the reference model
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    model_step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cycle();
    for (int n = 0; n < 3000; n++) begin
      logic       r, f, v, k;
      logic [7:0] m, d;
      r = ($urandom_range(0, 127) == 0);
      f = ($urandom_range(0, 63) == 0);
      v = $urandom_range(0, 1) == 1;
      k = ($urandom_range(0, 2) == 0);
      m = 8'($urandom);
      if ($urandom_range(0, 7) == 0) m = 8'h00;
      d = 8'($urandom) & 8'($urandom) & 8'($urandom);
      drive(r, f, v, m, d, k);
      model_step(r, f, v, m, d, k);
      cycle();
      check_out("rand", n, !m_active, m_resp, m_active, m_to);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
